// File: rtl/milano_pkg.sv
// Shared types and constants for the milano core CSR block.
// Holds CSR addresses, the Zicsr op encoding, write masks and small helpers.
package milano_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'b01,
    CSR_RS = 2'b10,
    CSR_RC = 2'b11
  } csr_op_e;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // Only MIE (bit 3) and MPIE (bit 7) are stored; MPP is hardwired to M-mode.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
  // Only MSIE (bit 3) and MTIE (bit 7) are stored.
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0088;
  // Vector-style registers keep word alignment.
  localparam logic [31:0] ALIGN_WMASK   = 32'hFFFF_FFFC;
  // RV32I + M extension flags.
  localparam logic [31:0] MISA_VAL      = 32'h4000_1100;

  localparam int unsigned MIP_MSIP_BIT = 3;
  localparam int unsigned MIP_MTIP_BIT = 7;

  // Zicsr read-modify-write result.
  function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_RW:  res = operand;
      CSR_RS:  res = old_val | operand;
      CSR_RC:  res = old_val & ~operand;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Read-only CSRs among the implemented set.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr == CSR_MISA) || (addr == CSR_MIP) || (addr == CSR_MHARTID);
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent low/high half write ports.
// A write to either half replaces that half, holds the other, and
// suppresses the increment for that cycle. Wraps naturally at 2^64.
module csr_counter64
  import milano_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;

  // Counter register: writes win over the increment.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (lo_we_i || hi_we_i) begin
      if (lo_we_i) cnt_q[31:0]  <= wdata_i;
      if (hi_we_i) cnt_q[63:32] <= wdata_i;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file for the milano core.
// Serves trap-controller full writes and execute-stage Zicsr RMW ops through
// one shared write port (trap controller has priority), samples interrupt
// lines into mip and exports the live trap-related CSRs.
// Optional feature macro: CSR_COUNTERS_EN enables mcycle/minstret counters;
// without it the counter addresses read 0, are legal, and ignore writes.
module csr_regfile
  import milano_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter logic [31:0] HART_ID   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        ex_csr_en_i,
  input  logic [1:0]  ex_csr_op_i,
  input  logic [11:0] ex_csr_addr_i,
  input  logic [31:0] ex_csr_operand_i,
  output logic [31:0] ex_csr_rdata_o,
  output logic        ex_csr_illegal_o,

  input  logic        ctrl_csr_we_i,
  input  logic [11:0] ctrl_csr_waddr_i,
  input  logic [31:0] ctrl_csr_wdata_i,

  input  logic        timer_irq_i,
  input  logic        sw_irq_i,
  input  logic        instr_retire_i,

  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mip_o
);

  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] mip_q;

  logic [31:0] ex_old;
  logic        ex_addr_valid;
  logic        ex_write_req;
  logic        ex_illegal;

  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_cnt;
  logic [63:0] minstret_cnt;
`endif

  // Read mux: current value of the execute-stage address and its validity.
  always_comb begin
    ex_old        = '0;
    ex_addr_valid = 1'b1;
    case (ex_csr_addr_i)
      CSR_MSTATUS:  ex_old = mstatus_q | MSTATUS_MPP;
      CSR_MISA:     ex_old = MISA_VAL;
      CSR_MIE:      ex_old = mie_q;
      CSR_MTVEC:    ex_old = mtvec_q;
      CSR_MSCRATCH: ex_old = mscratch_q;
      CSR_MEPC:     ex_old = mepc_q;
      CSR_MCAUSE:   ex_old = mcause_q;
      CSR_MTVAL:    ex_old = mtval_q;
      CSR_MIP:      ex_old = mip_q;
      CSR_MHARTID:  ex_old = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    ex_old = mcycle_cnt[31:0];
      CSR_MCYCLEH:   ex_old = mcycle_cnt[63:32];
      CSR_MINSTRET:  ex_old = minstret_cnt[31:0];
      CSR_MINSTRETH: ex_old = minstret_cnt[63:32];
`else
      CSR_MCYCLE, CSR_MCYCLEH,
      CSR_MINSTRET, CSR_MINSTRETH: ex_old = '0;
`endif
      default: begin
        ex_old        = '0;
        ex_addr_valid = 1'b0;
      end
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it never trips the
  // read-only check.
  always_comb begin
    ex_write_req = 1'b0;
    if (ex_csr_en_i) begin
      if (ex_csr_op_i == CSR_RW) begin
        ex_write_req = 1'b1;
      end else if ((ex_csr_op_i == CSR_RS) || (ex_csr_op_i == CSR_RC)) begin
        ex_write_req = (ex_csr_operand_i != '0);
      end
    end
  end

  assign ex_illegal       = ex_csr_en_i &&
                            (!ex_addr_valid || (ex_write_req && csr_is_ro(ex_csr_addr_i)));
  assign ex_csr_illegal_o = ex_illegal;
  assign ex_csr_rdata_o   = (ex_csr_en_i && !ex_illegal) ? ex_old : '0;

  // Shared write port: a trap-controller write drops any execute write.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (ctrl_csr_we_i) begin
      wr_en   = 1'b1;
      wr_addr = ctrl_csr_waddr_i;
      wr_data = ctrl_csr_wdata_i;
    end else if (ex_write_req && !ex_illegal) begin
      wr_en   = 1'b1;
      wr_addr = ex_csr_addr_i;
      wr_data = csr_apply_op(ex_csr_op_i, ex_old, ex_csr_operand_i);
    end
  end

  // CSR storage with per-register write masks; read-only and unknown
  // addresses fall through the decode and are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ALIGN_WMASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mip_q      <= '0;
    end else begin
      mip_q               <= '0;
      mip_q[MIP_MTIP_BIT] <= timer_irq_i;
      mip_q[MIP_MSIP_BIT] <= sw_irq_i;
      if (wr_en) begin
        case (wr_addr)
          CSR_MSTATUS:  mstatus_q  <= wr_data & MSTATUS_WMASK;
          CSR_MIE:      mie_q      <= wr_data & MIE_WMASK;
          CSR_MTVEC:    mtvec_q    <= wr_data & ALIGN_WMASK;
          CSR_MSCRATCH: mscratch_q <= wr_data;
          CSR_MEPC:     mepc_q     <= wr_data & ALIGN_WMASK;
          CSR_MCAUSE:   mcause_q   <= wr_data;
          CSR_MTVAL:    mtval_q    <= wr_data;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (1'b1),
    .lo_we_i (wr_en && (wr_addr == CSR_MCYCLE)),
    .hi_we_i (wr_en && (wr_addr == CSR_MCYCLEH)),
    .wdata_i (wr_data),
    .cnt_o   (mcycle_cnt)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (instr_retire_i),
    .lo_we_i (wr_en && (wr_addr == CSR_MINSTRET)),
    .hi_we_i (wr_en && (wr_addr == CSR_MINSTRETH)),
    .wdata_i (wr_data),
    .cnt_o   (minstret_cnt)
  );
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire_i;
`endif

  assign csr_mstatus_o = mstatus_q | MSTATUS_MPP;
  assign csr_mepc_o    = mepc_q;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mie_o     = mie_q;
  assign csr_mip_o     = mip_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: table of execute/ctrl vectors with a
// scoreboard queue, plus hand sequences for interrupt sampling and counters.
module tb_csr_regfile;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_csr_en_i;
  logic [1:0]  ex_csr_op_i;
  logic [11:0] ex_csr_addr_i;
  logic [31:0] ex_csr_operand_i;
  logic [31:0] ex_csr_rdata_o;
  logic        ex_csr_illegal_o;
  logic        ctrl_csr_we_i;
  logic [11:0] ctrl_csr_waddr_i;
  logic [31:0] ctrl_csr_wdata_i;
  logic        timer_irq_i;
  logic        sw_irq_i;
  logic        instr_retire_i;
  logic [31:0] csr_mstatus_o, csr_mepc_o, csr_mtvec_o, csr_mie_o, csr_mip_o;

  csr_regfile #(.MTVEC_RST(32'h0000_0100), .HART_ID(32'h0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_csr_en_i(ex_csr_en_i), .ex_csr_op_i(ex_csr_op_i),
    .ex_csr_addr_i(ex_csr_addr_i), .ex_csr_operand_i(ex_csr_operand_i),
    .ex_csr_rdata_o(ex_csr_rdata_o), .ex_csr_illegal_o(ex_csr_illegal_o),
    .ctrl_csr_we_i(ctrl_csr_we_i), .ctrl_csr_waddr_i(ctrl_csr_waddr_i),
    .ctrl_csr_wdata_i(ctrl_csr_wdata_i),
    .timer_irq_i(timer_irq_i), .sw_irq_i(sw_irq_i), .instr_retire_i(instr_retire_i),
    .csr_mstatus_o(csr_mstatus_o), .csr_mepc_o(csr_mepc_o), .csr_mtvec_o(csr_mtvec_o),
    .csr_mie_o(csr_mie_o), .csr_mip_o(csr_mip_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        chk;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] operand;
    logic        cwe;
    logic [11:0] caddr;
    logic [31:0] cwdata;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [1:0] RW = 2'b01, RS = 2'b10, RC = 2'b11;

  function automatic vec_t mk(input logic chk, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] opnd, input logic cwe, input logic [11:0] caddr,
                              input logic [31:0] cwd, input logic [31:0] rd, input logic ill);
    vec_t v;
    v.chk = chk; v.op = op; v.addr = addr; v.operand = opnd;
    v.cwe = cwe; v.caddr = caddr; v.cwdata = cwd; v.exp_rdata = rd; v.exp_ill = ill;
    return v;
  endfunction

  function automatic vec_t rd(input logic [11:0] addr, input logic [31:0] exp);
    return mk(1'b1, RS, addr, 32'h0, 1'b0, 12'h0, 32'h0, exp, 1'b0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
      ex_csr_en_i = 1'b0; ctrl_csr_we_i = 1'b0;
    end
  endtask

  // One cycle of stimulus; the expectation rides the scoreboard until the
  // mid-cycle sample of the combinational read port.
  task automatic apply_vec(input vec_t v, input string nm);
    vec_t e;
    @(posedge clk_i); #1;
    ex_csr_en_i      = 1'b1;
    ex_csr_op_i      = v.op;
    ex_csr_addr_i    = v.addr;
    ex_csr_operand_i = v.operand;
    ctrl_csr_we_i    = v.cwe;
    ctrl_csr_waddr_i = v.caddr;
    ctrl_csr_wdata_i = v.cwdata;
    if (v.chk) sb.push_back(v);
    #3;
    if (v.chk) begin
      e = sb.pop_front();
      check({nm, "_rdata"}, ex_csr_rdata_o, e.exp_rdata);
      check({nm, "_illegal"}, {31'b0, ex_csr_illegal_o}, {31'b0, e.exp_ill});
    end
  endtask

  initial begin
    rst_ni = 1'b0; ex_csr_en_i = 1'b0; ex_csr_op_i = RW; ex_csr_addr_i = 12'h0;
    ex_csr_operand_i = '0; ctrl_csr_we_i = 1'b0; ctrl_csr_waddr_i = '0;
    ctrl_csr_wdata_i = '0; timer_irq_i = 1'b0; sw_irq_i = 1'b0; instr_retire_i = 1'b0;

    // Table: reset reads, RMW ops, masks, illegal accesses, conflicts.
    vecs.push_back(rd(CSR_MSTATUS,  32'h0000_1800));
    vecs.push_back(rd(CSR_MISA,     32'h4000_1100));
    vecs.push_back(rd(CSR_MIE,      32'h0));
    vecs.push_back(rd(CSR_MTVEC,    32'h0000_0100));
    vecs.push_back(rd(CSR_MSCRATCH, 32'h0));
    vecs.push_back(rd(CSR_MEPC,     32'h0));
    vecs.push_back(rd(CSR_MCAUSE,   32'h0));
    vecs.push_back(rd(CSR_MTVAL,    32'h0));
    vecs.push_back(rd(CSR_MIP,      32'h0));
    vecs.push_back(rd(CSR_MHARTID,  32'h0));
    vecs.push_back(mk(1, RW, CSR_MTVEC, 32'h8000_0123, 0, 0, 0, 32'h0000_0100, 0));
    vecs.push_back(rd(CSR_MTVEC, 32'h8000_0120));
    vecs.push_back(mk(1, RS, CSR_MSTATUS, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_1800, 0));
    vecs.push_back(mk(1, RC, CSR_MSTATUS, 32'h0000_0008, 0, 0, 0, 32'h0000_1888, 0));
    vecs.push_back(rd(CSR_MSTATUS, 32'h0000_1880));
    vecs.push_back(mk(1, RW, CSR_MIE, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 0));
    vecs.push_back(rd(CSR_MIE, 32'h0000_0088));
    vecs.push_back(mk(1, RW, CSR_MEPC, 32'h1234_5677, 0, 0, 0, 32'h0, 0));
    vecs.push_back(rd(CSR_MEPC, 32'h1234_5674));
    vecs.push_back(mk(1, RW, CSR_MIP, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1));
    vecs.push_back(rd(CSR_MIP, 32'h0));
    vecs.push_back(mk(1, RS, CSR_MIP, 32'h0000_0001, 0, 0, 0, 32'h0, 1));
    vecs.push_back(mk(1, RW, CSR_MISA, 32'h0, 0, 0, 0, 32'h0, 1));
    vecs.push_back(mk(1, RC, CSR_MHARTID, 32'h0, 0, 0, 0, 32'h0, 0));
    vecs.push_back(rd(12'h7C0, 32'h0));
    vecs[$].exp_ill = 1'b1;
    vecs.push_back(mk(1, RW, CSR_MSCRATCH, 32'h55, 1, CSR_MCAUSE, 32'h8000_0007, 32'h0, 0));
    vecs.push_back(rd(CSR_MSCRATCH, 32'h0));
    vecs.push_back(rd(CSR_MCAUSE, 32'h8000_0007));
    vecs.push_back(mk(1, RS, CSR_MSTATUS, 32'h0, 1, CSR_MSTATUS, 32'hFFFF_FFFF, 32'h0000_1880, 0));
    vecs.push_back(rd(CSR_MSTATUS, 32'h0000_1888));
    vecs.push_back(mk(1, RW, CSR_MTVAL, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, RC, CSR_MTVAL, 32'h0000_FFFF, 0, 0, 0, 32'hDEAD_BEEF, 0));
    vecs.push_back(rd(CSR_MTVAL, 32'hDEAD_0000));
    vecs.push_back(mk(1, RS, CSR_MTVEC, 32'h0, 1, CSR_MTVEC, 32'h0000_0203, 32'h8000_0120, 0));
    vecs.push_back(rd(CSR_MTVEC, 32'h0000_0200));
    vecs.push_back(mk(1, RS, CSR_MCAUSE, 32'h0, 1, CSR_MISA, 32'h0, 32'h8000_0007, 0));
    vecs.push_back(rd(CSR_MISA, 32'h4000_1100));
`ifndef CSR_COUNTERS_EN
    vecs.push_back(rd(CSR_MCYCLE, 32'h0));
    vecs.push_back(mk(1, RW, CSR_MCYCLEH, 32'h5, 0, 0, 0, 32'h0, 0));
    vecs.push_back(rd(CSR_MCYCLEH, 32'h0));
    vecs.push_back(rd(CSR_MINSTRET, 32'h0));
    vecs.push_back(rd(CSR_MINSTRETH, 32'h0));
`endif

    // Reset and registered outputs while held/just released.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mtvec_during", csr_mtvec_o, 32'h0000_0100);
    rst_ni = 1'b1;
    #3;
    check("rst_mstatus", csr_mstatus_o, 32'h0000_1800);
    check("rst_mie", csr_mie_o, 32'h0);
    check("rst_mip", csr_mip_o, 32'h0);
    check("rst_mepc", csr_mepc_o, 32'h0);
    ex_csr_addr_i = 12'h7C0;
    #1;
    check("illegal_when_idle", {31'b0, ex_csr_illegal_o}, 32'h0);

    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));
    idle(1);
    #3;
    check("out_mstatus", csr_mstatus_o, 32'h0000_1888);
    check("out_mtvec", csr_mtvec_o, 32'h0000_0200);
    check("out_mie", csr_mie_o, 32'h0000_0088);
    check("out_mepc", csr_mepc_o, 32'h1234_5674);

    // One-cycle timer pulse appears in mip for exactly one cycle.
    @(posedge clk_i); #1;
    timer_irq_i = 1'b1; sw_irq_i = 1'b1;
    #3;
    check("mip_pulse_pre", csr_mip_o, 32'h0);
    apply_vec(rd(CSR_MIP, 32'h0000_0088), "mip_pulse_rd");
    timer_irq_i = 1'b0;
    check("mip_pulse_on", csr_mip_o, 32'h0000_0088);
    apply_vec(rd(CSR_MIP, 32'h0000_0008), "mip_pulse_off_rd");
    sw_irq_i = 1'b0;
    check("mip_pulse_off", csr_mip_o, 32'h0000_0008);
    apply_vec(mk(1, RW, CSR_MIP, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 1), "mip_wr_ro");
    idle(1);
    #3;
    check("mip_unchanged", csr_mip_o, 32'h0);

`ifdef CSR_COUNTERS_EN
    // 64-bit wrap through half writes.
    apply_vec(mk(0, RW, CSR_MCYCLE,  32'hFFFF_FFFE, 0, 0, 0, 0, 0), "mcyc_wlo");
    apply_vec(mk(0, RW, CSR_MCYCLEH, 32'hFFFF_FFFF, 0, 0, 0, 0, 0), "mcyc_whi");
    apply_vec(rd(CSR_MCYCLE,  32'hFFFF_FFFE), "mcyc_lo0");
    apply_vec(rd(CSR_MCYCLEH, 32'hFFFF_FFFF), "mcyc_hi1");
    apply_vec(rd(CSR_MCYCLE,  32'h0), "mcyc_wrap_lo");
    apply_vec(rd(CSR_MCYCLEH, 32'h0), "mcyc_wrap_hi");
    apply_vec(mk(0, RW, CSR_MCYCLE, 32'd100, 0, 0, 0, 0, 0), "mcyc_w100");
    apply_vec(rd(CSR_MCYCLE, 32'd100), "mcyc_hold");
    apply_vec(rd(CSR_MCYCLE, 32'd101), "mcyc_inc");
    // minstret: writes suppress the increment, then five retirements.
    instr_retire_i = 1'b1;
    apply_vec(mk(0, RW, CSR_MINSTRET,  32'h0, 0, 0, 0, 0, 0), "mret_wlo");
    apply_vec(mk(0, RW, CSR_MINSTRETH, 32'h0, 0, 0, 0, 0, 0), "mret_whi");
    idle(5);
    apply_vec(rd(CSR_MINSTRET, 32'd5), "mret_lo");
    instr_retire_i = 1'b0;
    apply_vec(rd(CSR_MINSTRET, 32'd5), "mret_lo_hold");
    apply_vec(rd(CSR_MINSTRETH, 32'h0), "mret_hi");
    apply_vec(mk(1, RS, 12'h7C0, 32'h0, 0, 0, 0, 32'h0, 1), "addr_7c0");
`endif
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
